spi_cmd_arbiter: RTL and testbench
==================================

Name: spi_cmd_arbiter

Overview:
Shares the single SPI master command port between two requesters: req0 is the UART host command path and req1 is the on-chip register sequencer. Performs round-robin grant and issues one cmdUpdate pulse per transaction. Waits for SPI completion, enforces a watchdog timeout and a minimum inter-transaction gap, and routes read data and status back to the owning requester. Sits between uart_rx_top/sequencer and spi_master_top in the clk40M domain.

Parameters:
TIMEOUT, 4096, max clk40M cycles from cmdUpdate to spi_done before abort (>=2)
GAP, 4, idle cycles enforced after each completion before next grant (>=0)
ERR_W, 8, width of saturating error counter

Ports:
clk40M  in  1  system clock
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 accepted (handshake when valid&ready)
req0_cmd  in  8  requester 0 command byte
req0_addr  in  16  requester 0 address {msb,lsb}
req0_data  in  16  requester 0 write data {msb,lsb}
req1_valid/req1_ready/req1_cmd/req1_addr/req1_data  same as req0, requester 1
rsp0_valid  out  1  one-cycle response pulse to requester 0
rsp1_valid  out  1  one-cycle response pulse to requester 1
rsp_rdData  out  16  read data, valid with rspN_valid
rsp_err  out  1  timeout flag, valid with rspN_valid
cmdUpdate  out  1  one-cycle strobe to SPI master
o_cmd, o_addrMsb, o_addrLsb, o_dataMsb, o_dataLsb  out  8 each  latched command fields, stable from cmdUpdate until return to IDLE
spi_done  in  1  SPI master transaction-complete pulse
spi_rdData  in  16  SPI read data, sampled on spi_done
busy  out  1  high in any state except IDLE
errCnt  out  ERR_W  saturating timeout count

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; all outputs 0; rrLast=1 (req0 wins first tie); timer=0; errCnt=0. Reset mid-transaction aborts silently, no rsp pulse.
- States: IDLE, ISSUE, WAIT_DONE, GAP_WAIT.
- IDLE: grant is combinational. Only one valid -> that requester wins. Both valid -> requester != rrLast wins. reqN_ready = (state==IDLE) & grant==N; at most one ready per cycle, never ready outside IDLE. On handshake: latch fields (addr[15:8]->o_addrMsb, etc.), record owner, -> ISSUE.
- ISSUE: cmdUpdate=1 for exactly this cycle; timer cleared; -> WAIT_DONE. Latency from handshake to cmdUpdate = 1 cycle.
- WAIT_DONE: timer increments each cycle.
  - spi_done=1: capture spi_rdData into rsp_rdData, rsp_err=0, pulse rsp<owner>_valid next cycle, rrLast=owner, -> GAP_WAIT.
  - timer==TIMEOUT-1 without done: rsp_rdData=0, rsp_err=1, pulse rsp<owner>_valid, errCnt+=1 saturating at all-ones, rrLast=owner, -> GAP_WAIT.
  - done and timeout in the same cycle: done wins, no error.
- GAP_WAIT: counts GAP cycles, then -> IDLE; GAP=0 -> IDLE directly on the next cycle.
- rsp_rdData/rsp_err hold until the next response. rspN_valid pulses are mutually exclusive.
- spi_done outside WAIT_DONE is ignored.
- A requester dropping valid before ready is permitted; no grant is latched.

Optional Feature:
SPI_ARB_FIXED_PRIO_EN defined: req0 always wins when both are valid and rrLast is unused; req1 can starve. Undefined: round-robin as above.

Test Plan:
- Single req0 write cmd=0x02 addr=0x1234 data=0xBEEF; spi_done 10 cycles after cmdUpdate -> cmdUpdate 1 cycle after handshake with o_addrMsb=0x12, o_dataLsb=0xEF; rsp0_valid=1 for one cycle, rsp_err=0, busy low GAP+1 cycles later.
- req0 and req1 both held valid for 4 transactions -> grants req0, req1, req0, req1; each cmdUpdate separated by ≥ GAP idle cycles; with SPI_ARB_FIXED_PRIO_EN all 4 go to req0.
- req1 read with spi_rdData=0xA55A on done -> rsp1_valid pulse with rsp_rdData=0xA55A; rsp0_valid stays 0.
- spi_done never asserted, TIMEOUT=16 -> rsp_err=1 and rsp_rdData=0 exactly 16 cycles after cmdUpdate; errCnt=1; next request served normally; with ERR_W=2, 5 timeouts -> errCnt=3.
- spi_done on the timeout cycle -> rsp_err=0, errCnt unchanged. Stray spi_done in IDLE -> no rsp pulse.
- rst=1 during WAIT_DONE -> next cycle state IDLE, all outputs 0, no rsp pulse; pending req0 is granted first after reset.

Source files
------------

// File: rtl/spi_cmd_arbiter_if.sv
// Requester, response and SPI-command signal bundle for spi_cmd_arbiter.
// The slave modport is the arbiter's view; master is the view of its surroundings.
interface spi_cmd_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_cmd;
    logic [15:0] req0_addr;
    logic [15:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_cmd;
    logic [15:0] req1_addr;
    logic [15:0] req1_data;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [15:0] rsp_rdData;
    logic        rsp_err;
    logic        cmdUpdate;
    logic [7:0]  o_cmd;
    logic [7:0]  o_addrMsb;
    logic [7:0]  o_addrLsb;
    logic [7:0]  o_dataMsb;
    logic [7:0]  o_dataLsb;
    logic        spi_done;
    logic [15:0] spi_rdData;

    modport slave (
        input  req0_valid, req0_cmd, req0_addr, req0_data,
        input  req1_valid, req1_cmd, req1_addr, req1_data,
        input  spi_done, spi_rdData,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_rdData, rsp_err,
        output cmdUpdate, o_cmd, o_addrMsb, o_addrLsb, o_dataMsb, o_dataLsb
    );

    modport master (
        output req0_valid, req0_cmd, req0_addr, req0_data,
        output req1_valid, req1_cmd, req1_addr, req1_data,
        output spi_done, spi_rdData,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_rdData, rsp_err,
        input  cmdUpdate, o_cmd, o_addrMsb, o_addrLsb, o_dataMsb, o_dataLsb
    );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// Two-requester arbiter for the SPI master command port with watchdog and inter-transaction gap.
// Define SPI_ARB_FIXED_PRIO_EN to make req0 win every tie instead of round-robin.
module spi_cmd_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int GAP     = 4,
    parameter int ERR_W   = 8
) (
    input  logic             clk40M,
    input  logic             rst,
    spi_cmd_arbiter_if.slave bus,
    output logic             busy,
    output logic [ERR_W-1:0] errCnt
);
    localparam int TW       = $clog2(TIMEOUT);
    localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_END    = GW'(GAP_LAST);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP_WAIT  = 2'd3
    } state_t;

    state_t            state_r;
    logic              owner_r;
    logic              rr_last_r;
    logic [TW-1:0]     timer_r;
    logic [GW-1:0]     gap_cnt_r;
    logic [7:0]        cmd_r;
    logic [7:0]        addr_msb_r;
    logic [7:0]        addr_lsb_r;
    logic [7:0]        data_msb_r;
    logic [7:0]        data_lsb_r;
    logic              cmd_update_r;
    logic              rsp0_valid_r;
    logic              rsp1_valid_r;
    logic [15:0]       rsp_rd_data_r;
    logic              rsp_err_r;
    logic              busy_r;
    logic [ERR_W-1:0]  err_cnt_r;

    logic              grant_s;
    logic              grant_vld_s;
    logic              hs_s;

    // Grant selection: a lone requester wins; ties go away from the last owner.
    always_comb begin
        grant_s     = 1'b0;
        grant_vld_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_vld_s = 1'b1;
`ifdef SPI_ARB_FIXED_PRIO_EN
            grant_s     = 1'b0;
`else
            grant_s     = ~rr_last_r;
`endif
        end else if (bus.req0_valid) begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b0;
        end else if (bus.req1_valid) begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            grant_s     = 1'b0;
        end
    end

    assign hs_s           = (state_r == ST_IDLE) && grant_vld_s;
    assign bus.req0_ready = hs_s && !grant_s;
    assign bus.req1_ready = hs_s && grant_s;

    // Transaction FSM; timer_r counts cycles since the cmdUpdate cycle.
    always_ff @(posedge clk40M) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            owner_r       <= 1'b0;
            rr_last_r     <= 1'b1;
            timer_r       <= '0;
            gap_cnt_r     <= '0;
            cmd_r         <= 8'h00;
            addr_msb_r    <= 8'h00;
            addr_lsb_r    <= 8'h00;
            data_msb_r    <= 8'h00;
            data_lsb_r    <= 8'h00;
            cmd_update_r  <= 1'b0;
            rsp0_valid_r  <= 1'b0;
            rsp1_valid_r  <= 1'b0;
            rsp_rd_data_r <= 16'h0000;
            rsp_err_r     <= 1'b0;
            busy_r        <= 1'b0;
            err_cnt_r     <= '0;
        end else begin
            cmd_update_r <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        owner_r      <= grant_s;
                        cmd_r        <= grant_s ? bus.req1_cmd        : bus.req0_cmd;
                        addr_msb_r   <= grant_s ? bus.req1_addr[15:8] : bus.req0_addr[15:8];
                        addr_lsb_r   <= grant_s ? bus.req1_addr[7:0]  : bus.req0_addr[7:0];
                        data_msb_r   <= grant_s ? bus.req1_data[15:8] : bus.req0_data[15:8];
                        data_lsb_r   <= grant_s ? bus.req1_data[7:0]  : bus.req0_data[7:0];
                        timer_r      <= '0;
                        cmd_update_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_r <= TW'(1);
                    state_r <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (bus.spi_done || (timer_r == TIMER_LAST)) begin
                        // Completion beats timeout when both land together.
                        if (bus.spi_done) begin
                            rsp_rd_data_r <= bus.spi_rdData;
                            rsp_err_r     <= 1'b0;
                        end else begin
                            rsp_rd_data_r <= 16'h0000;
                            rsp_err_r     <= 1'b1;
                            if (err_cnt_r != {ERR_W{1'b1}}) begin
                                err_cnt_r <= err_cnt_r + ERR_W'(1);
                            end
                        end
                        rsp0_valid_r <= !owner_r;
                        rsp1_valid_r <= owner_r;
                        rr_last_r    <= owner_r;
                        gap_cnt_r    <= '0;
                        if (GAP == 0) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_GAP_WAIT;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_GAP_WAIT: begin
                    if (gap_cnt_r == GAP_END) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmdUpdate  = cmd_update_r;
    assign bus.o_cmd      = cmd_r;
    assign bus.o_addrMsb  = addr_msb_r;
    assign bus.o_addrLsb  = addr_lsb_r;
    assign bus.o_dataMsb  = data_msb_r;
    assign bus.o_dataLsb  = data_lsb_r;
    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp_rdData = rsp_rd_data_r;
    assign bus.rsp_err    = rsp_err_r;
    assign busy           = busy_r;
    assign errCnt         = err_cnt_r;
endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Scoreboard bench for spi_cmd_arbiter (TIMEOUT=16, GAP=4, ERR_W=2).
module tb_spi_cmd_arbiter;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 4;
    localparam int ERR_W   = 2;

    logic             clk40M = 1'b0;
    logic             rst;
    logic             busy;
    logic [ERR_W-1:0] errCnt;

    spi_cmd_arbiter_if bus();

    spi_cmd_arbiter #(.TIMEOUT(TIMEOUT), .GAP(GAP), .ERR_W(ERR_W)) dut (
        .clk40M (clk40M),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .errCnt (errCnt)
    );

    always #5 clk40M = ~clk40M;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [15:0] data;
    } cmd_t;

    typedef struct packed {
        logic        owner;
        logic [15:0] rd;
        logic        err;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   vec  = 0;
    int   miss = 0;

    task automatic tick();
        @(posedge clk40M);
        #1;
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0; bus.req0_cmd = 8'h00; bus.req0_addr = 16'h0; bus.req0_data = 16'h0;
        bus.req1_valid = 1'b0; bus.req1_cmd = 8'h00; bus.req1_addr = 16'h0; bus.req1_data = 16'h0;
        bus.spi_done   = 1'b0; bus.spi_rdData = 16'h0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cmd_q.delete();
        rsp_q.delete();
    endtask

    // Raise valid, wait (bounded) for ready, handshake; returns in the ISSUE cycle.
    task automatic start_req(input logic n, input cmd_t c, output bit ok);
        ok = 1'b0;
        if (n == 1'b0) begin
            bus.req0_cmd = c.cmd; bus.req0_addr = c.addr; bus.req0_data = c.data; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_cmd = c.cmd; bus.req1_addr = c.addr; bus.req1_data = c.data; bus.req1_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < 40; i++) begin
            if ((n == 1'b0 && bus.req0_ready) || (n == 1'b1 && bus.req1_ready)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            tick();
            cmd_q.push_back(c);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if ({busy, bus.cmdUpdate, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.req0_ready, bus.req1_ready} !== 7'b0) begin
            miss++; $display("FAIL reset_ctrl: got %b required 0000000",
                {busy, bus.cmdUpdate, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.req0_ready, bus.req1_ready});
        end
        vec++;
        if ({bus.rsp_rdData, bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb} !== 56'h0) begin
            miss++; $display("FAIL reset_data: got %h required 0",
                {bus.rsp_rdData, bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb});
        end
        vec++;
        if (errCnt !== 2'd0) begin
            miss++; $display("FAIL reset_errcnt: got %0d required 0", errCnt);
        end
    endtask

    task automatic test_single_write();
        cmd_t c; cmd_t e; rsp_t er; bit ok;
        do_reset();
        c = '{cmd: 8'h02, addr: 16'h1234, data: 16'hBEEF};
        start_req(1'b0, c, ok);
        vec++;
        if (ok !== 1'b1) begin miss++; $display("FAIL sw_grant: ready never seen, got %b required 1", ok); end
        vec++;
        if (bus.cmdUpdate !== 1'b1) begin miss++; $display("FAIL sw_latency: cmdUpdate got %b required 1", bus.cmdUpdate); end
        vec++;
        if (cmd_q.size() == 0) begin
            miss++; $display("FAIL sw_fields: empty command scoreboard");
        end else begin
            e = cmd_q.pop_front();
            if ({bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb} !== {e.cmd, e.addr, e.data}) begin
                miss++; $display("FAIL sw_fields: got %h required %h",
                    {bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb}, {e.cmd, e.addr, e.data});
            end
        end
        vec++;
        if ({bus.o_addrMsb, bus.o_dataLsb} !== 16'h12EF) begin
            miss++; $display("FAIL sw_split: got %h required 12ef", {bus.o_addrMsb, bus.o_dataLsb});
        end
        rsp_q.push_back('{owner: 1'b0, rd: 16'h1111, err: 1'b0});
        tick();
        vec++;
        if (bus.cmdUpdate !== 1'b0) begin miss++; $display("FAIL sw_cmd_pulse: got %b required 0", bus.cmdUpdate); end
        repeat (9) tick();
        bus.spi_done = 1'b1; bus.spi_rdData = 16'h1111;
        tick();
        bus.spi_done = 1'b0; bus.spi_rdData = 16'h0000;
        vec++;
        if (rsp_q.size() == 0) begin
            miss++; $display("FAIL sw_rsp: empty response scoreboard");
        end else begin
            er = rsp_q.pop_front();
            if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData, bus.rsp_err} !== {er.owner, ~er.owner, er.rd, er.err}) begin
                miss++; $display("FAIL sw_rsp: got %h required %h",
                    {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData, bus.rsp_err}, {er.owner, ~er.owner, er.rd, er.err});
            end
        end
        vec++;
        if ({bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb} !== 40'h02_12_34_BE_EF) begin
            miss++; $display("FAIL sw_stable: got %h required 021234beef",
                {bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb});
        end
        tick();
        vec++;
        if (bus.rsp0_valid !== 1'b0) begin miss++; $display("FAIL sw_rsp_pulse: got %b required 0", bus.rsp0_valid); end
        tick(); tick();
        vec++;
        if (busy !== 1'b1) begin miss++; $display("FAIL sw_gap_busy: got %b required 1", busy); end
        tick();
        vec++;
        if (busy !== 1'b0) begin miss++; $display("FAIL sw_idle: got %b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        cmd_t c0; cmd_t c1; cmd_t e; rsp_t er; logic own; logic exp_own;
        int cyc; int n_hs; int n_cmd; int n_rsp; int last_rsp; int done_at; int viol;
        logic [15:0] cur_rd;
        do_reset();
        c0 = '{cmd: 8'h10, addr: 16'hA001, data: 16'h0A0A};
        c1 = '{cmd: 8'h20, addr: 16'hB002, data: 16'h0B0B};
        bus.req0_cmd = c0.cmd; bus.req0_addr = c0.addr; bus.req0_data = c0.data; bus.req0_valid = 1'b1;
        bus.req1_cmd = c1.cmd; bus.req1_addr = c1.addr; bus.req1_data = c1.data; bus.req1_valid = 1'b1;
        #1;
        cyc = 0; n_hs = 0; n_cmd = 0; n_rsp = 0; last_rsp = -100; done_at = -1; viol = 0; cur_rd = 16'h0;
        while (n_rsp < 4 && cyc < 400) begin
            bus.spi_done = 1'b0;
            if ((bus.req0_ready && bus.req1_ready) || (busy && (bus.req0_ready || bus.req1_ready))) viol++;
            if ((bus.req0_ready || bus.req1_ready) && n_hs < 4) begin
                own = bus.req1_ready;
`ifdef SPI_ARB_FIXED_PRIO_EN
                exp_own = 1'b0;
`else
                exp_own = (n_hs % 2 == 1) ? 1'b1 : 1'b0;
`endif
                vec++;
                if (own !== exp_own) begin miss++; $display("FAIL b2b_owner%0d: got %b required %b", n_hs, own, exp_own); end
                cmd_q.push_back(own ? c1 : c0);
                rsp_q.push_back('{owner: own, rd: 16'hC000 + 16'(n_hs), err: 1'b0});
                n_hs++;
            end
            if (bus.cmdUpdate) begin
                vec++;
                if (cmd_q.size() == 0) begin
                    miss++; $display("FAIL b2b_fields: empty command scoreboard");
                end else begin
                    e = cmd_q.pop_front();
                    if ({bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb} !== {e.cmd, e.addr, e.data}) begin
                        miss++; $display("FAIL b2b_fields: got %h required %h",
                            {bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb}, {e.cmd, e.addr, e.data});
                    end
                end
                if (n_cmd > 0) begin
                    vec++;
                    if (cyc - last_rsp < GAP + 1) begin
                        miss++; $display("FAIL b2b_gap: got %0d cycles required >= %0d", cyc - last_rsp, GAP + 1);
                    end
                end
                cur_rd  = 16'hC000 + 16'(n_cmd);
                done_at = cyc + 3;
                n_cmd++;
            end
            if (cyc == done_at) begin
                bus.spi_done = 1'b1; bus.spi_rdData = cur_rd;
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                vec++;
                if (rsp_q.size() == 0) begin
                    miss++; $display("FAIL b2b_rsp: empty response scoreboard");
                end else begin
                    er = rsp_q.pop_front();
                    if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData, bus.rsp_err} !== {er.owner, ~er.owner, er.rd, er.err}) begin
                        miss++; $display("FAIL b2b_rsp: got %h required %h",
                            {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData, bus.rsp_err}, {er.owner, ~er.owner, er.rd, er.err});
                    end
                end
                n_rsp++;
                last_rsp = cyc;
            end
            tick();
            cyc++;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.spi_done = 1'b0;
        vec++;
        if (n_rsp !== 4) begin miss++; $display("FAIL b2b_count: got %0d responses required 4", n_rsp); end
        vec++;
        if (viol !== 0) begin miss++; $display("FAIL b2b_ready: got %0d ready violations required 0", viol); end
    endtask

    task automatic test_read_req1();
        rsp_t er; bit ok;
        do_reset();
        start_req(1'b1, '{cmd: 8'h03, addr: 16'h00AB, data: 16'h0000}, ok);
        vec++;
        if ({ok, bus.cmdUpdate, bus.o_cmd} !== {1'b1, 1'b1, 8'h03}) begin
            miss++; $display("FAIL rd_issue: got %b required 1100000011", {ok, bus.cmdUpdate, bus.o_cmd});
        end
        cmd_q.delete();
        rsp_q.push_back('{owner: 1'b1, rd: 16'hA55A, err: 1'b0});
        tick(); tick();
        bus.spi_done = 1'b1; bus.spi_rdData = 16'hA55A;
        tick();
        bus.spi_done = 1'b0; bus.spi_rdData = 16'h0000;
        vec++;
        if (rsp_q.size() == 0) begin
            miss++; $display("FAIL rd_rsp: empty response scoreboard");
        end else begin
            er = rsp_q.pop_front();
            if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData, bus.rsp_err} !== {er.owner, ~er.owner, er.rd, er.err}) begin
                miss++; $display("FAIL rd_rsp: got %h required %h",
                    {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData, bus.rsp_err}, {er.owner, ~er.owner, er.rd, er.err});
            end
        end
        tick();
        vec++;
        if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData} !== {2'b00, 16'hA55A}) begin
            miss++; $display("FAIL rd_hold: got %h required 0a55a", {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData});
        end
    endtask

    task automatic test_timeout();
        rsp_t er; bit ok; int n; logic [ERR_W-1:0] exp_cnt;
        do_reset();
        bus.spi_rdData = 16'hFFFF;
        start_req(1'b0, '{cmd: 8'h05, addr: 16'h0101, data: 16'h0202}, ok);
        cmd_q.delete();
        vec++;
        if ({ok, bus.cmdUpdate} !== 2'b11) begin miss++; $display("FAIL to_issue: got %b required 11", {ok, bus.cmdUpdate}); end
        rsp_q.push_back('{owner: 1'b0, rd: 16'h0000, err: 1'b1});
        wait_rsp(ok, n);
        vec++;
        if (ok !== 1'b1 || n !== TIMEOUT) begin
            miss++; $display("FAIL to_latency: got %0d cycles (seen %b) required %0d", n, ok, TIMEOUT);
        end
        vec++;
        if (rsp_q.size() == 0) begin
            miss++; $display("FAIL to_rsp: empty response scoreboard");
        end else begin
            er = rsp_q.pop_front();
            if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData, bus.rsp_err} !== {er.owner, ~er.owner, er.rd, er.err}) begin
                miss++; $display("FAIL to_rsp: got %h required %h",
                    {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_rdData, bus.rsp_err}, {er.owner, ~er.owner, er.rd, er.err});
            end
        end
        vec++;
        if (errCnt !== 2'd1) begin miss++; $display("FAIL to_errcnt: got %0d required 1", errCnt); end
        wait_idle(ok);
        start_req(1'b1, '{cmd: 8'h06, addr: 16'h0303, data: 16'h0404}, ok);
        cmd_q.delete();
        tick();
        bus.spi_done = 1'b1; bus.spi_rdData = 16'h5A5A;
        tick();
        bus.spi_done = 1'b0;
        vec++;
        if ({ok, bus.rsp1_valid, bus.rsp_rdData, bus.rsp_err, errCnt} !== {1'b1, 1'b1, 16'h5A5A, 1'b0, 2'd1}) begin
            miss++; $display("FAIL to_recover: got %h required %h",
                {ok, bus.rsp1_valid, bus.rsp_rdData, bus.rsp_err, errCnt}, {1'b1, 1'b1, 16'h5A5A, 1'b0, 2'd1});
        end
        exp_cnt = 2'd1;
        for (int k = 0; k < 4; k++) begin
            wait_idle(ok);
            start_req(logic'(k % 2), '{cmd: 8'h07, addr: 16'h0505, data: 16'h0606}, ok);
            cmd_q.delete();
            wait_rsp(ok, n);
            exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
            vec++;
            if ({ok, bus.rsp_err, errCnt} !== {1'b1, 1'b1, exp_cnt}) begin
                miss++; $display("FAIL to_sat%0d: got %b required %b", k, {ok, bus.rsp_err, errCnt}, {1'b1, 1'b1, exp_cnt});
            end
        end
        bus.spi_rdData = 16'h0000;
    endtask

    task automatic test_done_on_timeout();
        bit ok; int n; int stray;
        do_reset();
        start_req(1'b0, '{cmd: 8'h08, addr: 16'h0707, data: 16'h0808}, ok);
        wait_rsp(ok, n);
        wait_idle(ok);
        start_req(1'b1, '{cmd: 8'h09, addr: 16'h0909, data: 16'h0A0A}, ok);
        cmd_q.delete();
        repeat (TIMEOUT - 1) tick();
        bus.spi_done = 1'b1; bus.spi_rdData = 16'h1234;
        tick();
        bus.spi_done = 1'b0; bus.spi_rdData = 16'h0000;
        vec++;
        if ({bus.rsp1_valid, bus.rsp_rdData, bus.rsp_err, errCnt} !== {1'b1, 16'h1234, 1'b0, 2'd1}) begin
            miss++; $display("FAIL dto_rsp: got %h required %h",
                {bus.rsp1_valid, bus.rsp_rdData, bus.rsp_err, errCnt}, {1'b1, 16'h1234, 1'b0, 2'd1});
        end
        wait_idle(ok);
        bus.spi_done = 1'b1; bus.spi_rdData = 16'hDEAD;
        tick();
        bus.spi_done = 1'b0;
        stray = 0;
        repeat (6) begin
            if (bus.rsp0_valid || bus.rsp1_valid || busy || bus.rsp_rdData !== 16'h1234) stray++;
            tick();
        end
        vec++;
        if (stray !== 0) begin miss++; $display("FAIL stray_done: got %0d bad cycles required 0", stray); end
    endtask

    task automatic test_reset_mid();
        bit ok; int pulses;
        do_reset();
        start_req(1'b1, '{cmd: 8'h0B, addr: 16'h0B0B, data: 16'h0C0C}, ok);
        cmd_q.delete();
        tick(); tick(); tick();
        bus.req0_cmd = 8'h0D; bus.req0_addr = 16'h0D0D; bus.req0_data = 16'h0E0E; bus.req0_valid = 1'b1;
        bus.req1_cmd = 8'h0F; bus.req1_addr = 16'h0F0F; bus.req1_data = 16'h1010; bus.req1_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vec++;
        if ({busy, bus.cmdUpdate, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.rsp_rdData, errCnt} !== 23'h0) begin
            miss++; $display("FAIL rm_outputs: got %h required 0",
                {busy, bus.cmdUpdate, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.rsp_rdData, errCnt});
        end
        vec++;
        if ({bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb} !== 40'h0) begin
            miss++; $display("FAIL rm_fields: got %h required 0",
                {bus.o_cmd, bus.o_addrMsb, bus.o_addrLsb, bus.o_dataMsb, bus.o_dataLsb});
        end
        vec++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            miss++; $display("FAIL rm_first_grant: got %b required 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        vec++;
        if ({bus.cmdUpdate, bus.o_cmd} !== {1'b1, 8'h0D}) begin
            miss++; $display("FAIL rm_issue: got %h required 10d", {bus.cmdUpdate, bus.o_cmd});
        end
        pulses = 0;
        repeat (5) begin
            tick();
            if (bus.rsp0_valid || bus.rsp1_valid) pulses++;
        end
        vec++;
        if (pulses !== 0) begin miss++; $display("FAIL rm_no_rsp: got %0d pulses required 0", pulses); end
        do_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_req1();
        test_timeout();
        test_done_on_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
